// File: rtl/bus_edge_mon_pkg.sv
// rtl/bus_edge_mon_pkg.sv - shared types for the bus edge monitor
package bus_edge_mon_pkg;

    // Default counter width used by the event record type
    localparam int EV_CNT_W = 16;

    // Level-tracking FSM states
    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        SKEW = 2'd3
    } state_t;

    // One recorded transition: direction, mixed-interval flag, previous level duration
    typedef struct packed {
        logic                rise;
        logic                skew;
        logic [EV_CNT_W-1:0] width;
    } event_t;

endpackage

// File: rtl/bus_edge_mon_fifo.sv
// rtl/bus_edge_mon_fifo.sv - synchronous event FIFO with simultaneous push/pop
module bus_edge_mon_fifo #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_MAX);
    assign head_data = mem_q[rd_q];

    // Next storage, pointers and occupancy; a push into a full FIFO is legal only alongside a pop
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers; entries cleared so the head reads zero out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_edge_monitor.sv
// rtl/bus_edge_monitor.sv - fan-out bus level/edge monitor with event FIFO (option: BUS_EDGE_MON_SKEW_CHECK_EN)
module bus_edge_monitor
    import bus_edge_mon_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] y_in,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic             ev_rise,
    output logic [CNT_W-1:0] ev_width,
    output logic             ev_skew,
    output logic [CNT_W-1:0] edge_count,
    output logic             overflow,
    output logic             skew_err
);

    localparam int EV_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] WONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] WMAX = '1;

    logic [WIDTH-1:0] samp_q, samp_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic             overflow_q, overflow_d;
    logic             is_all1, is_all0;
    logic             ev_gen, ev_rise_gen, ev_skew_gen;
    logic             fifo_full, fifo_empty, pop, push;
    logic [EV_W-1:0]  head;

`ifdef BUS_EDGE_MON_SKEW_CHECK_EN
    logic             prev_lvl_q, prev_lvl_d;
    logic             skew_err_q, skew_err_d;

    assign is_all1  = &samp_q;
    assign is_all0  = ~|samp_q;
    assign skew_err = skew_err_q;
`else
    logic             samp_unused;

    // Only bit 0 decides the level; the remaining bits are deliberately ignored
    assign is_all1     = samp_q[0];
    assign is_all0     = ~samp_q[0];
    assign samp_unused = ^samp_q;
    assign skew_err    = 1'b0;
`endif

    assign samp_d   = y_in;
    assign wcnt_inc = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + WONE;

    // Level tracking FSM: measures how long each level lasts and flags transitions
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        ev_gen      = 1'b0;
        ev_rise_gen = 1'b0;
        ev_skew_gen = 1'b0;
`ifdef BUS_EDGE_MON_SKEW_CHECK_EN
        prev_lvl_d  = prev_lvl_q;
        skew_err_d  = skew_err_q;
`endif
        case (state_q)
            INIT: begin
                if (is_all0) begin
                    state_d = LOW;
                    wcnt_d  = WONE;
                end else if (is_all1) begin
                    state_d = HIGH;
                    wcnt_d  = WONE;
                end
            end
            LOW: begin
                if (is_all1) begin
                    ev_gen      = 1'b1;
                    ev_rise_gen = 1'b1;
                    state_d     = HIGH;
                    wcnt_d      = WONE;
                end else if (is_all0) begin
                    wcnt_d = wcnt_inc;
                end
`ifdef BUS_EDGE_MON_SKEW_CHECK_EN
                else begin
                    prev_lvl_d = 1'b0;
                    state_d    = SKEW;
                    wcnt_d     = wcnt_inc;
                end
`endif
            end
            HIGH: begin
                if (is_all0) begin
                    ev_gen  = 1'b1;
                    state_d = LOW;
                    wcnt_d  = WONE;
                end else if (is_all1) begin
                    wcnt_d = wcnt_inc;
                end
`ifdef BUS_EDGE_MON_SKEW_CHECK_EN
                else begin
                    prev_lvl_d = 1'b1;
                    state_d    = SKEW;
                    wcnt_d     = wcnt_inc;
                end
`endif
            end
`ifdef BUS_EDGE_MON_SKEW_CHECK_EN
            SKEW: begin
                if (!is_all1 && !is_all0) begin
                    wcnt_d = wcnt_inc;
                end else if (is_all1 != prev_lvl_q) begin
                    ev_gen      = 1'b1;
                    ev_rise_gen = is_all1;
                    ev_skew_gen = 1'b1;
                    state_d     = is_all1 ? HIGH : LOW;
                    wcnt_d      = WONE;
                end else begin
                    skew_err_d = 1'b1;
                    state_d    = prev_lvl_q ? HIGH : LOW;
                    wcnt_d     = wcnt_inc;
                end
            end
`endif
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign pop  = ev_valid && ev_ready;
    assign push = ev_gen && (!fifo_full || pop);

    // Event bookkeeping: every generated event counts, dropped ones set the sticky overflow
    always_comb begin
        edge_count_d = edge_count_q + {{(CNT_W-1){1'b0}}, ev_gen};
        overflow_d   = overflow_q | (ev_gen && !push);
    end

    // Sampler, FSM and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q       <= '0;
            state_q      <= INIT;
            wcnt_q       <= '0;
            edge_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            samp_q       <= samp_d;
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            edge_count_q <= edge_count_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef BUS_EDGE_MON_SKEW_CHECK_EN
    // Level held before a mixed interval and the sticky glitch flag
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_lvl_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            prev_lvl_q <= prev_lvl_d;
            skew_err_q <= skew_err_d;
        end
    end
`endif

    bus_edge_mon_fifo #(
        .DATA_W (EV_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({ev_rise_gen, ev_skew_gen, wcnt_q}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign ev_valid   = !fifo_empty;
    assign ev_rise    = head[EV_W-1];
    assign ev_skew    = head[EV_W-2];
    assign ev_width   = head[CNT_W-1:0];
    assign edge_count = edge_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bus_edge_monitor.sv
// tb/tb_bus_edge_monitor.sv - self-checking bench for bus_edge_monitor (option: BUS_EDGE_MON_SKEW_CHECK_EN)
module tb_bus_edge_monitor;

    typedef bus_edge_mon_pkg::event_t event_t;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] y_in = '0;
    logic        ev_ready = 1'b0;
    logic        ev_valid, ev_rise, ev_skew, overflow, skew_err;
    logic [15:0] ev_width, edge_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    event_t      m_q[$];
    logic [31:0] m_samp;
    int          m_lvl;
    int          m_run;
    bit          m_mixed;
    int          m_ec;
    bit          m_ovf;
    bit          m_serr;

    always #5 clk = ~clk;

    bus_edge_monitor #(
        .WIDTH      (32),
        .CNT_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .y_in       (y_in),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_rise    (ev_rise),
        .ev_width   (ev_width),
        .ev_skew    (ev_skew),
        .edge_count (edge_count),
        .overflow   (overflow),
        .skew_err   (skew_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_samp  = '0;
        m_lvl   = -1;
        m_run   = 0;
        m_mixed = 0;
        m_ec    = 0;
        m_ovf   = 0;
        m_serr  = 0;
    endtask

    // One clock of the reference: look at the sampled bus, decide on an event, then queue it
    task automatic model_edge(input logic [31:0] y, input logic rdy);
        int     cls;
        bit     do_pop;
        bit     ev;
        event_t e;
        do_pop = (m_q.size() > 0) && rdy;
        ev     = 0;
        e      = '0;
`ifdef BUS_EDGE_MON_SKEW_CHECK_EN
        cls = (m_samp == ONES) ? 1 : ((m_samp == 32'h0) ? 0 : 2);
`else
        cls = int'(m_samp[0]);
`endif
        if (m_lvl < 0) begin
            if (cls != 2) begin
                m_lvl = cls;
                m_run = 1;
            end
        end else if (cls == 2) begin
            m_run++;
            m_mixed = 1;
        end else if (cls != m_lvl) begin
            ev      = 1;
            e.rise  = (cls == 1);
            e.skew  = m_mixed;
            e.width = (m_run > 65535) ? 16'hFFFF : 16'(m_run);
            m_lvl   = cls;
            m_run   = 1;
            m_mixed = 0;
        end else begin
            if (m_mixed) m_serr = 1;
            m_run++;
            m_mixed = 0;
        end
        if (do_pop) void'(m_q.pop_front());
        if (ev) begin
            m_ec = (m_ec + 1) % 65536;
            if (m_q.size() < 4) m_q.push_back(e);
            else m_ovf = 1;
        end
        m_samp = y;
    endtask

    task automatic compare_all();
        check_eq("ev_valid", ev_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check_eq("ev_rise", ev_rise, m_q[0].rise);
            check_eq("ev_width", ev_width, m_q[0].width);
            check_eq("ev_skew", ev_skew, m_q[0].skew);
        end
        check_eq("edge_count", edge_count, m_ec);
        check_eq("overflow", overflow, m_ovf);
        check_eq("skew_err", skew_err, m_serr);
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, compare at the next negedge
    task automatic cyc(input logic [31:0] y, input logic rdy);
        y_in     = y;
        ev_ready = rdy;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(y, rdy);
        @(negedge clk);
        if (!rst) compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(32'h0, 1'b0);
        cyc(32'h0, 1'b0);
        rst = 1'b0;
        check_eq("rst_valid", ev_valid, 1'b0);
        check_eq("rst_rise", ev_rise, 1'b0);
        check_eq("rst_width", ev_width, 16'd0);
        check_eq("rst_skew", ev_skew, 1'b0);
        check_eq("rst_edge_count", edge_count, 16'd0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_skew_err", skew_err, 1'b0);
    endtask

    initial begin
        int seen;
        int base_ec;
        @(negedge clk);
        do_reset();

        // Low for 10 samples (the reset value of the sampler is the first), then all ones
        for (int i = 0; i < 9; i++) cyc(32'h0, 1'b1);
        cyc(ONES, 1'b1);
        cyc(ONES, 1'b1);
        check_eq("t1_rise", ev_rise, 1'b1);
        check_eq("t1_width", ev_width, 16'd10);
        check_eq("t1_skew", ev_skew, 1'b0);
        check_eq("t1_edge_count", edge_count, 16'd1);

        // Four high samples, three half-bus samples, then low
        cyc(ONES, 1'b1);
        cyc(ONES, 1'b1);
        for (int i = 0; i < 3; i++) cyc(32'h0000_FFFF, 1'b1);
        cyc(32'h0, 1'b1);
        cyc(32'h0, 1'b1);
        check_eq("t2_rise", ev_rise, 1'b0);
        check_eq("t2_width", ev_width, 16'd7);
`ifdef BUS_EDGE_MON_SKEW_CHECK_EN
        check_eq("t2_skew", ev_skew, 1'b1);
`else
        check_eq("t2_skew", ev_skew, 1'b0);
`endif

        // Four low samples, a two-sample single-bit glitch, two more low, then high
        cyc(32'h0, 1'b1);
        cyc(32'h0, 1'b1);
        cyc(32'h1, 1'b1);
        cyc(32'h1, 1'b1);
`ifndef BUS_EDGE_MON_SKEW_CHECK_EN
        check_eq("t3_nsk_rise", ev_rise, 1'b1);
        check_eq("t3_nsk_width", ev_width, 16'd4);
        check_eq("t3_nsk_skew", ev_skew, 1'b0);
        check_eq("t3_nsk_skew_err", skew_err, 1'b0);
`endif
        cyc(32'h0, 1'b1);
        cyc(32'h0, 1'b1);
        cyc(ONES, 1'b1);
        cyc(ONES, 1'b1);
`ifdef BUS_EDGE_MON_SKEW_CHECK_EN
        check_eq("t3_skew_err", skew_err, 1'b1);
        check_eq("t3_width", ev_width, 16'd8);
        check_eq("t3_rise", ev_rise, 1'b1);
        check_eq("t3_edge_count", edge_count, 16'd3);
`endif

        // Six toggles with the consumer stalled: four kept, two dropped
        cyc(ONES, 1'b1);
        cyc(ONES, 1'b1);
        base_ec = m_ec;
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 3; k++) cyc((t % 2 == 0) ? 32'h0 : ONES, 1'b0);
        end
        cyc(ONES, 1'b0);
        cyc(ONES, 1'b0);
        check_eq("t4_overflow", overflow, 1'b1);
        check_eq("t4_edge_count", edge_count, 16'(base_ec + 6));
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ev_valid) seen++;
            cyc(ONES, 1'b1);
        end
        check_eq("t4_drained", seen, 4);

        // Reset with events queued discards them
        cyc(32'h0, 1'b0);
        cyc(32'h0, 1'b0);
        cyc(32'h0, 1'b0);
        do_reset();

        // Fill the FIFO, then pop on exactly the edge that pushes the fifth event
        for (int i = 0; i < 3; i++) cyc(32'h0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 3; k++) cyc((t % 2 == 0) ? ONES : 32'h0, 1'b0);
        end
        check_eq("t5_full_valid", ev_valid, 1'b1);
        cyc(ONES, 1'b0);
        cyc(ONES, 1'b1);
        cyc(ONES, 1'b0);
        check_eq("t5_overflow", overflow, 1'b0);
        check_eq("t5_edge_count", edge_count, 16'd5);
        check_eq("t5_new_head_rise", ev_rise, 1'b0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ev_valid) seen++;
            cyc(ONES, 1'b1);
        end
        check_eq("t5_occupancy", seen, 4);

        // Random runs of low, high and mixed bus values with a random consumer
        for (int r = 0; r < 400; r++) begin
            int          kind;
            int          len;
            logic [31:0] v;
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                v   = 32'h0;
                len = $urandom_range(1, 6);
            end else if (kind < 8) begin
                v   = ONES;
                len = $urandom_range(1, 6);
            end else begin
                v   = $urandom();
                len = $urandom_range(1, 3);
            end
            for (int k = 0; k < len; k++) begin
                cyc(v, ($urandom_range(0, 9) < 7));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
